sdram_read_arbiter: RTL

- Shares the single SDRAM read port among N_REQ requester units using round-robin arbitration.
- Drives the select input of the 32-way SDRAM read mux, which is combinational and routes addr/cnt/start from the selected requester and broadcasts data/valid/done to all.
- Holds the grant for one whole burst, from the requester's read_start to the SDRAM's read_done, then rotates priority.
- Gates read_start so only the granted requester can launch a burst, and only once per grant.

---
 rtl/sdram_read_arbiter_pkg.sv | 18 +
 rtl/sdram_read_arbiter_rr_pick.sv | 35 +++
 rtl/sdram_read_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sdram_read_arbiter_pkg.sv
// Shared types and constants for the SDRAM read-port arbiter and its read mux.
package sdram_read_arbiter_pkg;

  localparam int SDRAM_RD_PORTS = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Width of the grant timeout counter; at least one bit even when the timeout is disabled.
  function automatic int tmo_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sdram_read_arbiter_rr_pick.sv
// Round-robin winner selection: first set request at or above rr_ptr, wrapping modulo N_REQ.
module rr_pick
  import sdram_read_arbiter_pkg::*;
#(
  parameter int N_REQ = SDRAM_RD_PORTS,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl_req;
  logic [2*N_REQ-1:0] masked_req;

  // The lower copy is masked below rr_ptr and the upper copy is left whole, so the
  // lowest set bit of the doubled vector is the wrap-around winner.
  always_comb begin
    dbl_req    = {req, req};
    masked_req = '0;
    for (int i = 0; i < 2 * N_REQ; i++) begin
      masked_req[i] = dbl_req[i] && (i >= int'(rr_ptr));
    end
  end

  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = 2 * N_REQ - 1; i >= 0; i--) begin
      if (masked_req[i]) idx = SEL_W'(i % N_REQ);
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin owner of the shared SDRAM read port: grants one requester per burst
// and gates read_start so each grant launches at most one burst.
module sdram_read_arbiter
  import sdram_read_arbiter_pkg::*;
#(
  parameter int N_REQ   = SDRAM_RD_PORTS,
  parameter int SEL_W   = $clog2(N_REQ),
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_read_start,
  output logic             sdram_read_start,
  input  logic             sdram_read_done,
  output logic             busy,
  output logic             timeout_pulse,
  output arb_state_e       dbg_state,
  output logic [SEL_W-1:0] dbg_rr_ptr
);

  localparam int              TMO_W    = tmo_width(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REQ - 1);

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_pulse_q;

  logic [SEL_W-1:0] rr_ptr_d;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Priority moves to the requester just after the one that last held the port.
  assign rr_ptr_d = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);

  // Handshake: a requester holds req until it is granted and its start has been
  // accepted; the start is accepted only in GRANT, and the port stays owned until
  // the SDRAM controller answers with a read_done pulse in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            sel_q     <= pick_idx;
            tmo_cnt_q <= '0;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (mux_read_start) begin
            state_q <= BUSY;
          end else if (!req[sel_q]) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
            grant_q     <= '0;
            rr_ptr_q    <= rr_ptr_d;
            tmo_pulse_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        BUSY: begin
          if (sdram_read_done) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          // sel is left alone so the last beat and read_done stay routed this cycle.
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant            = grant_q;
  assign sel              = sel_q;
  assign timeout_pulse    = tmo_pulse_q;
  assign sdram_read_start = mux_read_start && (state_q == GRANT);
  assign busy             = (state_q == GRANT) || (state_q == BUSY);
  assign dbg_state        = state_q;
  assign dbg_rr_ptr       = rr_ptr_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_grant_sel:     assert property (@(posedge clk) disable iff (!rst_n)
                                    (grant_q != '0) |-> grant_q[sel_q]);
  a_start_grant:   assert property (@(posedge clk) disable iff (!rst_n)
                                    sdram_read_start |-> (state_q == GRANT));

endmodule
